cdb_arbiter: RTL

Common Data Bus arbiter and broadcaster for the Tomasulo core. Functional units (adder, multiplier, load unit, …) hold a completed result with `result_valid` until they see their own tag broadcast on the CDB. This block collects those held results, picks one per cycle with round-robin priority, and drives the registered `cdb_valid`/`cdb_tag`/`cdb_data` broadcast. Reservation stations, the register status table and the FUs themselves consume that broadcast.

---
 rtl/tomasulo_pkg.sv | 21 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/rr_picker.sv | 41 ++++
 rtl/cdb_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Types and constants shared by the CDB arbiter, the reservation stations and the FUs.
// The broadcast record travels as cdb_t wherever the default widths apply.
package tomasulo_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic            valid;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } cdb_t;

  // Successor of idx in a ring of n slots.
  function automatic int next_idx(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports and the registered CDB broadcast, bundled as one bus.
// master = FU side (drives held results), slave = arbiter side (drives the CDB).
interface cdb_arbiter_if #(
  parameter int N_FU  = 4,
  parameter int XLEN  = tomasulo_pkg::XLEN,
  parameter int TAG_W = tomasulo_pkg::TAG_W
);

  localparam int SRC_W = $clog2(N_FU);

  logic [N_FU-1:0]            fu_valid;
  logic [N_FU-1:0][TAG_W-1:0] fu_tag;
  logic [N_FU-1:0][XLEN-1:0]  fu_result;

  logic                       cdb_valid;
  logic [TAG_W-1:0]           cdb_tag;
  logic [XLEN-1:0]            cdb_data;
  logic [SRC_W-1:0]           cdb_src;
  logic [15:0]                conflict_cnt;

  modport master (
    output fu_valid, fu_tag, fu_result,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt
  );

  modport slave (
    input  fu_valid, fu_tag, fu_result,
    output cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// No state and no flow control; the caller registers the result.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int DW  = 2 * N;
  localparam int DIW = $clog2(DW);

  logic [DW-1:0]  dbl;
  logic [DW-1:0]  masked;
  logic [DIW-1:0] hit;

  // The upper copy of req supplies the wrapped candidates, so one
  // lowest-set-bit search over the masked double vector covers the ring.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ~((DW'(1) << ptr) - DW'(1));
    any    = 1'b0;
    hit    = '0;
    for (int j = 0; j < DW; j++) begin
      if (!any && masked[j]) begin
        any = 1'b1;
        hit = DIW'(j);
      end
    end
    idx   = (hit >= DIW'(N)) ? IW'(hit - DIW'(N)) : IW'(hit);
    grant = '0;
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one held FU result broadcast per cycle, one cycle after eligibility.
// FUs hold results until their own grant is seen; all outputs are flops with no input-to-output path.
module cdb_arbiter #(
  parameter int N_FU  = 4,
  parameter int XLEN  = tomasulo_pkg::XLEN,
  parameter int TAG_W = tomasulo_pkg::TAG_W
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  import tomasulo_pkg::*;

  localparam int SRC_W = $clog2(N_FU);

  logic [N_FU-1:0]  elig;
  logic [N_FU-1:0]  grant_oh;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic             multi;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  sel_data;

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  data_q;
  logic [SRC_W-1:0] src_q;
  logic [SRC_W-1:0] rr_ptr;
  logic [15:0]      conflict_q;

  // The FU on the bus still shows valid until the coming edge; keep it out.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_FU; i++) begin
      elig[i] = bus.fu_valid[i] && !(valid_q && (src_q == SRC_W'(i)));
    end
  end

  assign multi = ($countones(elig) >= 2);

  rr_picker #(
    .N  (N_FU),
    .IW (SRC_W)
  ) u_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (grant_oh[i]) begin
        sel_tag  = sel_tag | bus.fu_tag[i];
        sel_data = sel_data | bus.fu_result[i];
      end
    end
  end

  // Tag, data and source hold when idle; consumers qualify them with valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
      src_q      <= '0;
      rr_ptr     <= '0;
      conflict_q <= '0;
    end else begin
      valid_q <= grant_any;
      if (grant_any) begin
        tag_q  <= sel_tag;
        data_q <= sel_data;
        src_q  <= grant_idx;
        rr_ptr <= SRC_W'(next_idx(int'(grant_idx), N_FU));
      end
      if (multi && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign bus.cdb_valid    = valid_q;
  assign bus.cdb_tag      = tag_q;
  assign bus.cdb_data     = data_q;
  assign bus.cdb_src      = src_q;
  assign bus.conflict_cnt = conflict_q;

endmodule
